udm_uart_rx: RTL

Byte-oriented UART receiver that sits directly upstream of the UDM debug bridge inside `sigma`. It converts the asynchronous serial `rx_i` line (8N1, LSB first) into a valid/ready byte stream for the UDM command decoder. It uses a runtime-programmable bit-period divider, so one netlist serves every baud rate the host driver selects.

---
 rtl/udm_uart_pkg.sv | 22 ++
 rtl/sync_ff.sv | 25 ++
 rtl/udm_uart_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/udm_uart_pkg.sv
// rtl/udm_uart_pkg.sv - shared types and constants for the UDM UART receiver
package udm_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int          UART_DATA_W     = 8;
  localparam logic [31:0] DIV_115200_100M = 32'd868;
  localparam logic [31:0] DIV_19200_100M  = 32'd5208;
  localparam logic [31:0] DIV_9600_100M   = 32'd10417;

  // Raise a requested clocks-per-bit value to the smallest supported one
  function automatic logic [31:0] clamp_div(input logic [31:0] div, input logic [31:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flop synchronizer with programmable reset value
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; the last stage is the safe copy
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/udm_uart_rx.sv
// rtl/udm_uart_rx.sv - 8N1 UART receiver with runtime divider and valid/ready output
module udm_uart_rx #(
  parameter int MIN_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [31:0] div_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);
  import udm_uart_pkg::*;

  localparam logic [31:0] MIN_DIV_W = 32'(MIN_DIV);

  uart_rx_state_t state;
  uart_rx_state_t state_n;
  logic           rx_s;
  logic           rx_prev;
  logic [31:0]    div_q;
  logic [31:0]    div_clamped;
  logic [31:0]    cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           tick;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign div_clamped = clamp_div(div_i, MIN_DIV_W);
  assign tick        = (cnt == 32'd0);

  // Frame sequencing: start edge, mid-bit samples, stop check, break recovery
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rx_prev && !rx_s) state_n = START;
      START:   if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:    if (tick && idx == 3'd7) state_n = STOP;
      STOP:    if (tick) state_n = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath, bit timing, output register and handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      div_q       <= MIN_DIV_W;
      cnt         <= 32'd0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      busy_o      <= (state_n != IDLE);
      rx_prev     <= rx_s;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (state_n == START) begin
            // Divider is frozen for the whole frame; first sample lands mid start bit
            div_q <= div_clamped;
            cnt   <= (div_clamped >> 1) - 32'd1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              cnt <= div_q - 32'd1;
              idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= div_q - 32'd1;
            if (idx != 3'd7) idx <= idx + 3'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              // A full register that is being drained this cycle can take the new byte
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
